rs_alu_sched: RTL and testbench

RS_ALU_SCHED -- requirements
Module: rs_alu_sched

---
 rtl/rs_alu_sched.sv | 181 ++++++++++++++++++
 tb/tb_rs_alu_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu_sched.sv
// Reservation station for the ALU: holds dispatched ops, captures CDB results for waiting
// operands, and issues the lowest-index ready entry each cycle through registered outputs.
module rs_alu_sched #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             disp_valid,
  input  logic [5:0]       disp_opcode,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic [ROB_W-1:0] disp_qk,
  input  logic             disp_wj,
  input  logic             disp_wk,
  input  logic [31:0]      disp_A,
  input  logic [31:0]      disp_pc,
  input  logic [ROB_W-1:0] disp_rob_pos,
  input  logic             cdb_valid,
  input  logic [ROB_W-1:0] cdb_rob_pos,
  input  logic [31:0]      cdb_val,
  output logic             rs_full,
  output logic             alu_valid,
  output logic [5:0]       alu_opcode,
  output logic [31:0]      alu_vj,
  output logic [31:0]      alu_vk,
  output logic [31:0]      alu_A,
  output logic [31:0]      alu_pc,
  output logic [ROB_W-1:0] alu_rob_pos
);

  localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  typedef struct packed {
    logic             busy;
    logic [5:0]       opcode;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic             wj;
    logic             wk;
    logic [31:0]      a;
    logic [31:0]      pc;
    logic [ROB_W-1:0] rob_pos;
  } entry_t;

  entry_t ent_q [RS_SIZE];
  entry_t ent_d [RS_SIZE];
  entry_t new_e;

  logic             alu_valid_q,  alu_valid_d;
  logic [5:0]       alu_opcode_q, alu_opcode_d;
  logic [31:0]      alu_vj_q,     alu_vj_d;
  logic [31:0]      alu_vk_q,     alu_vk_d;
  logic [31:0]      alu_a_q,      alu_a_d;
  logic [31:0]      alu_pc_q,     alu_pc_d;
  logic [ROB_W-1:0] alu_rob_q,    alu_rob_d;

  logic [RS_SIZE-1:0] busy_vec;
  logic               free_found, iss_found;
  logic [IDX_W-1:0]   free_idx, iss_idx;

  // Selection uses register state only, so a freshly dispatched or woken entry waits a cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    iss_found  = 1'b0;
    iss_idx    = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      busy_vec[i] = ent_q[i].busy;
      if (!free_found && !ent_q[i].busy) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (!iss_found && ent_q[i].busy && !ent_q[i].wj && !ent_q[i].wk) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
      end
    end
  end

  // Full is judged before this cycle's issue; a slot freed now is reusable next cycle.
  assign rs_full = &busy_vec;

  always_comb begin
    new_e         = '0;
    new_e.busy    = 1'b1;
    new_e.opcode  = disp_opcode;
    new_e.vj      = disp_vj;
    new_e.vk      = disp_vk;
    new_e.qj      = disp_qj;
    new_e.qk      = disp_qk;
    new_e.wj      = disp_wj;
    new_e.wk      = disp_wk;
    new_e.a       = disp_A;
    new_e.pc      = disp_pc;
    new_e.rob_pos = disp_rob_pos;
    if (disp_wj && cdb_valid && disp_qj == cdb_rob_pos) begin
      new_e.vj = cdb_val;
      new_e.wj = 1'b0;
    end
    if (disp_wk && cdb_valid && disp_qk == cdb_rob_pos) begin
      new_e.vk = cdb_val;
      new_e.wk = 1'b0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) ent_d[i] = ent_q[i];
    alu_valid_d  = 1'b0;
    alu_opcode_d = '0;
    alu_vj_d     = '0;
    alu_vk_d     = '0;
    alu_a_d      = '0;
    alu_pc_d     = '0;
    alu_rob_d    = '0;
    if (clear) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) ent_d[i].busy = 1'b0;
    end else if (rdy) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (ent_q[i].busy && cdb_valid) begin
          if (ent_q[i].wj && ent_q[i].qj == cdb_rob_pos) begin
            ent_d[i].vj = cdb_val;
            ent_d[i].wj = 1'b0;
          end
          if (ent_q[i].wk && ent_q[i].qk == cdb_rob_pos) begin
            ent_d[i].vk = cdb_val;
            ent_d[i].wk = 1'b0;
          end
        end
      end
      if (iss_found) begin
        ent_d[iss_idx].busy = 1'b0;
        alu_valid_d  = 1'b1;
        alu_opcode_d = ent_q[iss_idx].opcode;
        alu_vj_d     = ent_q[iss_idx].vj;
        alu_vk_d     = ent_q[iss_idx].vk;
        alu_a_d      = ent_q[iss_idx].a;
        alu_pc_d     = ent_q[iss_idx].pc;
        alu_rob_d    = ent_q[iss_idx].rob_pos;
      end
      // The free slot is never the issuing slot, so both writes can land together.
      if (disp_valid && !rs_full) ent_d[free_idx] = new_e;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      alu_valid_q  <= 1'b0;
      alu_opcode_q <= '0;
      alu_vj_q     <= '0;
      alu_vk_q     <= '0;
      alu_a_q      <= '0;
      alu_pc_q     <= '0;
      alu_rob_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      alu_valid_q  <= alu_valid_d;
      alu_opcode_q <= alu_opcode_d;
      alu_vj_q     <= alu_vj_d;
      alu_vk_q     <= alu_vk_d;
      alu_a_q      <= alu_a_d;
      alu_pc_q     <= alu_pc_d;
      alu_rob_q    <= alu_rob_d;
    end
  end

  assign alu_valid   = alu_valid_q;
  assign alu_opcode  = alu_opcode_q;
  assign alu_vj      = alu_vj_q;
  assign alu_vk      = alu_vk_q;
  assign alu_A       = alu_a_q;
  assign alu_pc      = alu_pc_q;
  assign alu_rob_pos = alu_rob_q;

endmodule

// File: tb/tb_rs_alu_sched.sv
// Directed bench for rs_alu_sched: a vector table for single-entry flows, then hand-written
// sequences for full-station, priority under stall, flush and asynchronous reset.
module tb_rs_alu_sched;

  localparam logic [5:0] ADD = 6'h01;
  localparam logic [5:0] SUB = 6'h02;
  localparam logic [5:0] OR_ = 6'h03;
  localparam logic [5:0] AND_ = 6'h04;
  localparam logic [5:0] XOR_ = 6'h05;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        disp_valid;
  logic [5:0]  disp_opcode;
  logic [31:0] disp_vj, disp_vk, disp_A, disp_pc;
  logic [3:0]  disp_qj, disp_qk, disp_rob_pos;
  logic        disp_wj, disp_wk;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_pos;
  logic [31:0] cdb_val;
  logic        rs_full, alu_valid;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_vj, alu_vk, alu_A, alu_pc;
  logic [3:0]  alu_rob_pos;

  int checks = 0;
  int failures = 0;

  rs_alu_sched #(.RS_SIZE(8), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .disp_valid(disp_valid), .disp_opcode(disp_opcode),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
    .disp_wj(disp_wj), .disp_wk(disp_wk), .disp_A(disp_A), .disp_pc(disp_pc),
    .disp_rob_pos(disp_rob_pos),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
    .rs_full(rs_full), .alu_valid(alu_valid), .alu_opcode(alu_opcode),
    .alu_vj(alu_vj), .alu_vk(alu_vk), .alu_A(alu_A), .alu_pc(alu_pc),
    .alu_rob_pos(alu_rob_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [5:0]  op;
    logic [31:0] vj, vk;
    logic [3:0]  qj, qk, rob;
    logic        wj, wk;
    logic        cv;
    logic [3:0]  ctag;
    logic [31:0] cval;
    logic        ev;
    logic [5:0]  eop;
    logic [31:0] evj, evk;
    logic [3:0]  erob;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t v(input logic dv, input logic [5:0] op, input logic [31:0] vj, vk,
                             input logic [3:0] qj, qk, rob, input logic wj, wk,
                             input logic cv, input logic [3:0] ctag, input logic [31:0] cval,
                             input logic ev, input logic [5:0] eop, input logic [31:0] evj, evk,
                             input logic [3:0] erob);
    vec_t r;
    r.dv = dv; r.op = op; r.vj = vj; r.vk = vk; r.qj = qj; r.qk = qk; r.rob = rob;
    r.wj = wj; r.wk = wk; r.cv = cv; r.ctag = ctag; r.cval = cval;
    r.ev = ev; r.eop = eop; r.evj = evj; r.evk = evk; r.erob = erob;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    disp_valid = 1'b0; disp_opcode = '0; disp_vj = '0; disp_vk = '0;
    disp_qj = '0; disp_qk = '0; disp_wj = 1'b0; disp_wk = 1'b0;
    disp_A = '0; disp_pc = '0; disp_rob_pos = '0;
    cdb_valid = 1'b0; cdb_rob_pos = '0; cdb_val = '0;
    rdy = 1'b1; clear = 1'b0;
  endtask

  task automatic set_disp(input logic [5:0] op, input logic [31:0] vj, vk,
                          input logic [3:0] qj, qk, input logic wj, wk, input logic [3:0] rob);
    disp_valid = 1'b1; disp_opcode = op; disp_vj = vj; disp_vk = vk;
    disp_qj = qj; disp_qk = qk; disp_wj = wj; disp_wk = wk; disp_rob_pos = rob;
    disp_A  = 32'h1000 + 32'(rob);
    disp_pc = 32'h400 + 32'(rob) * 32'd4;
  endtask

  task automatic set_cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_rob_pos = tag; cdb_val = val;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic chk_issue(input string name, input logic ev, input logic [5:0] op,
                           input logic [31:0] vj, vk, input logic [3:0] rob);
    chk($sformatf("%s.valid", name), 32'(alu_valid), 32'(ev));
    if (ev) begin
      chk($sformatf("%s.opcode", name), 32'(alu_opcode), 32'(op));
      chk($sformatf("%s.vj", name), alu_vj, vj);
      chk($sformatf("%s.vk", name), alu_vk, vk);
      chk($sformatf("%s.rob", name), 32'(alu_rob_pos), 32'(rob));
      chk($sformatf("%s.A", name), alu_A, 32'h1000 + 32'(rob));
      chk($sformatf("%s.pc", name), alu_pc, 32'h400 + 32'(rob) * 32'd4);
    end else begin
      chk($sformatf("%s.vj0", name), alu_vj, 32'd0);
      chk($sformatf("%s.rob0", name), 32'(alu_rob_pos), 32'd0);
      chk($sformatf("%s.A0", name), alu_A, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0]  = v(1'b1, ADD,  32'd5,      32'd7,  4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,    1'b0, 6'd0, 32'd0,    32'd0,    4'd0);
    vt[1]  = v(1'b0, 6'd0, 32'd0,      32'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,    1'b1, ADD,  32'd5,    32'd7,    4'd3);
    vt[2]  = v(1'b0, 6'd0, 32'd0,      32'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,    1'b0, 6'd0, 32'd0,    32'd0,    4'd0);
    vt[3]  = v(1'b1, SUB,  32'hDEAD,   32'd2,  4'd6, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0,    1'b0, 6'd0, 32'd0,    32'd0,    4'd0);
    vt[4]  = v(1'b0, 6'd0, 32'd0,      32'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,    1'b0, 6'd0, 32'd0,    32'd0,    4'd0);
    vt[5]  = v(1'b0, 6'd0, 32'd0,      32'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd9, 32'd77,   1'b0, 6'd0, 32'd0,    32'd0,    4'd0);
    vt[6]  = v(1'b0, 6'd0, 32'd0,      32'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd6, 32'd10,   1'b0, 6'd0, 32'd0,    32'd0,    4'd0);
    vt[7]  = v(1'b0, 6'd0, 32'd0,      32'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,    1'b1, SUB,  32'd10,   32'd2,    4'd1);
    vt[8]  = v(1'b1, OR_,  32'hDEAD,   32'd1,  4'd4, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1, 4'd4, 32'h55,   1'b0, 6'd0, 32'd0,    32'd0,    4'd0);
    vt[9]  = v(1'b0, 6'd0, 32'd0,      32'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,    1'b1, OR_,  32'h55,   32'd1,    4'd2);
    vt[10] = v(1'b1, AND_, 32'd0,      32'd0,  4'd5, 4'd5, 4'd7, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0,    1'b0, 6'd0, 32'd0,    32'd0,    4'd0);
    vt[11] = v(1'b0, 6'd0, 32'd0,      32'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 32'h33,   1'b0, 6'd0, 32'd0,    32'd0,    4'd0);
    vt[12] = v(1'b0, 6'd0, 32'd0,      32'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,    1'b1, AND_, 32'h33,   32'h33,   4'd7);
    vt[13] = v(1'b0, 6'd0, 32'd0,      32'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,    1'b0, 6'd0, 32'd0,    32'd0,    4'd0);
    vt[14] = v(1'b1, ADD,  32'd1,      32'd2,  4'd0, 4'd0, 4'd8, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,    1'b0, 6'd0, 32'd0,    32'd0,    4'd0);
    vt[15] = v(1'b1, XOR_, 32'd3,      32'd4,  4'd0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,    1'b1, ADD,  32'd1,    32'd2,    4'd8);
    vt[16] = v(1'b0, 6'd0, 32'd0,      32'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,    1'b1, XOR_, 32'd3,    32'd4,    4'd9);
    vt[17] = v(1'b0, 6'd0, 32'd0,      32'd0,  4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,    1'b0, 6'd0, 32'd0,    32'd0,    4'd0);

    rst = 1'b0;
    set_idle();
    #12;
    chk_issue("reset", 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
    chk("reset.full", 32'(rs_full), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      set_idle();
      if (vt[i].dv) set_disp(vt[i].op, vt[i].vj, vt[i].vk, vt[i].qj, vt[i].qk,
                             vt[i].wj, vt[i].wk, vt[i].rob);
      if (vt[i].cv) set_cdb(vt[i].ctag, vt[i].cval);
      tick();
      chk_issue($sformatf("vec%0d", i), vt[i].ev, vt[i].eop, vt[i].evj, vt[i].evk, vt[i].erob);
      chk($sformatf("vec%0d.full", i), 32'(rs_full), 32'd0);
    end

    // Fill all eight entries with waiting ops (tags 8..15), then try a ninth.
    for (int i = 0; i < 8; i++) begin
      set_idle();
      set_disp(ADD, 32'hBAD0 + 32'(i), 32'(i), 4'(i + 8), 4'd0, 1'b1, 1'b0, 4'(i));
      tick();
      chk($sformatf("fill%0d.full", i), 32'(rs_full), (i == 7) ? 32'd1 : 32'd0);
    end
    set_idle();
    set_disp(ADD, 32'd1, 32'd1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd15);
    tick();
    chk("ninth.full", 32'(rs_full), 32'd1);
    chk("ninth.valid", 32'(alu_valid), 32'd0);
    set_idle();
    set_cdb(4'd10, 32'hAB);
    tick();
    chk("wake2.valid", 32'(alu_valid), 32'd0);
    chk("wake2.full", 32'(rs_full), 32'd1);
    set_idle();
    tick();
    chk_issue("iss2", 1'b1, ADD, 32'hAB, 32'd2, 4'd2);
    chk("iss2.full", 32'(rs_full), 32'd0);
    tick();
    chk("after2.valid", 32'(alu_valid), 32'd0);
    clear = 1'b1;
    tick();
    chk("flush1.full", 32'(rs_full), 32'd0);
    chk("flush1.valid", 32'(alu_valid), 32'd0);

    // Entries 1 and 5 wake on the same tag; a 3-cycle stall separates their issues.
    for (int i = 0; i < 6; i++) begin
      set_idle();
      set_disp(SUB, 32'h100 + 32'(i), 32'h10, (i == 1 || i == 5) ? 4'd3 : 4'd9, 4'd0,
               1'b1, 1'b0, 4'(i));
      tick();
    end
    set_idle();
    set_cdb(4'd3, 32'h77);
    tick();
    chk("prio.wake.valid", 32'(alu_valid), 32'd0);
    set_idle();
    tick();
    chk_issue("prio.e1", 1'b1, SUB, 32'h77, 32'h10, 4'd1);
    for (int i = 0; i < 3; i++) begin
      set_idle();
      rdy = 1'b0;
      set_disp(ADD, 32'd9, 32'd9, 4'd0, 4'd0, 1'b0, 1'b0, 4'd14);
      set_cdb(4'd9, 32'h99);
      tick();
      chk($sformatf("stall%0d.valid", i), 32'(alu_valid), 32'd0);
    end
    set_idle();
    tick();
    chk_issue("prio.e5", 1'b1, SUB, 32'h77, 32'h10, 4'd5);
    tick();
    chk_issue("prio.after", 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
    clear = 1'b1;
    tick();

    // Flush with four busy entries and a ready dispatch in the same cycle.
    for (int i = 0; i < 4; i++) begin
      set_idle();
      set_disp(OR_, 32'd0, 32'd1, 4'd12, 4'd0, 1'b1, 1'b0, 4'(i));
      tick();
    end
    set_idle();
    clear = 1'b1;
    set_disp(ADD, 32'd1, 32'd2, 4'd0, 4'd0, 1'b0, 1'b0, 4'd13);
    set_cdb(4'd12, 32'd1);
    tick();
    chk("clr.valid", 32'(alu_valid), 32'd0);
    chk("clr.full", 32'(rs_full), 32'd0);
    for (int i = 0; i < 3; i++) begin
      set_idle();
      set_cdb(4'd12, 32'd1);
      tick();
      chk($sformatf("clr.after%0d.valid", i), 32'(alu_valid), 32'd0);
    end

    // Asynchronous reset while one op is on the outputs and another is pending.
    set_idle();
    set_disp(ADD, 32'h11, 32'h22, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4);
    tick();
    set_idle();
    set_disp(ADD, 32'h33, 32'h44, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5);
    tick();
    chk_issue("pre_rst", 1'b1, ADD, 32'h11, 32'h22, 4'd4);
    set_idle();
    rst = 1'b0;
    #1;
    chk_issue("async_rst", 1'b0, 6'd0, 32'd0, 32'd0, 4'd0);
    chk("async_rst.full", 32'(rs_full), 32'd0);
    #2;
    rst = 1'b1;
    tick();
    chk("post_rst0.valid", 32'(alu_valid), 32'd0);
    tick();
    chk("post_rst1.valid", 32'(alu_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
